mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 82 ++++++++
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Purpose : bundles every request, reply and memory-handshake signal of the
//           memory arbiter so that the arbiter and its clients share a single
//           connection. Clock and reset are not part of the bundle.
// Signals :
//   op_read_from_op      requester -> arbiter  pulse, operation unit read
//   op_write_from_op     requester -> arbiter  pulse, operation unit write
//   io_write_from_io     requester -> arbiter  pulse, I/O unit write
//   pnl_read_from_pnl    requester -> arbiter  pulse, panel manual read
//   pnl_write_from_pnl   requester -> arbiter  pulse, panel manual write
//   clear_error_from_pnl requester -> arbiter  pulse, clears sticky errors
//   mem_ack_from_mem     memory    -> arbiter  pulse, access complete
//   mem_req_to_mem       arbiter   -> memory   level, access in progress
//   mem_we_to_mem        arbiter   -> memory   level, 1 = write
//   grant_to_mem[2:0]    arbiter   -> muxes    one-hot owner {pnl, io, op}
//   mem_reply_to_op      arbiter   -> op       pulse, access done
//   mem_write_reply_to_io arbiter  -> io       pulse, access done
//   mem_reply_to_pnl     arbiter   -> panel    pulse, access done
//   busy_to_pnl          arbiter   -> panel    level, busy
//   overrun_to_pnl       arbiter   -> panel    level, sticky overrun
//   timeout_to_pnl       arbiter   -> panel    level, sticky timeout
// Modports: master = arbiter side, slave = requester/memory side.
// ----------------------------------------------------------------------------
interface mem_arbiter_if;
    logic       op_read_from_op;
    logic       op_write_from_op;
    logic       io_write_from_io;
    logic       pnl_read_from_pnl;
    logic       pnl_write_from_pnl;
    logic       clear_error_from_pnl;
    logic       mem_ack_from_mem;
    logic       mem_req_to_mem;
    logic       mem_we_to_mem;
    logic [2:0] grant_to_mem;
    logic       mem_reply_to_op;
    logic       mem_write_reply_to_io;
    logic       mem_reply_to_pnl;
    logic       busy_to_pnl;
    logic       overrun_to_pnl;
    logic       timeout_to_pnl;

    // The arbiter consumes requests and the memory ack, and drives the rest.
    modport master (
        input  op_read_from_op,
        input  op_write_from_op,
        input  io_write_from_io,
        input  pnl_read_from_pnl,
        input  pnl_write_from_pnl,
        input  clear_error_from_pnl,
        input  mem_ack_from_mem,
        output mem_req_to_mem,
        output mem_we_to_mem,
        output grant_to_mem,
        output mem_reply_to_op,
        output mem_write_reply_to_io,
        output mem_reply_to_pnl,
        output busy_to_pnl,
        output overrun_to_pnl,
        output timeout_to_pnl
    );

    // Requesters and the memory model drive requests/ack and observe the rest.
    modport slave (
        output op_read_from_op,
        output op_write_from_op,
        output io_write_from_io,
        output pnl_read_from_pnl,
        output pnl_write_from_pnl,
        output clear_error_from_pnl,
        output mem_ack_from_mem,
        input  mem_req_to_mem,
        input  mem_we_to_mem,
        input  grant_to_mem,
        input  mem_reply_to_op,
        input  mem_write_reply_to_io,
        input  mem_reply_to_pnl,
        input  busy_to_pnl,
        input  overrun_to_pnl,
        input  timeout_to_pnl
    );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Purpose : arbitrates single memory accesses between three requesters
//           (operation unit, I/O unit, panel). Each requester has one pending
//           slot holding a read/write flag. An IDLE/BUSY/REPLY state machine
//           grants one owner at a time, holds the memory request until the
//           memory acks, then pulses that owner's reply for one cycle.
//           Accesses that see no ack within 255 BUSY cycles are dropped and
//           flagged as a timeout. Requests that land on an occupied slot, or
//           read+write pulsed together, flag an overrun.
// Ports   :
//   clk    in  system clock, all state changes on the rising edge
//   reset  in  synchronous active-high reset
//   bus    mem_arbiter_if.master, request/reply/memory signals
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  when defined the panel keeps top priority while
//                           op and io alternate on ties (io first after
//                           reset); when undefined priority is fixed
//                           pnl > io > op.
// ----------------------------------------------------------------------------
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_REPLY = 2'd2;

    // BUSY cycle index at which the access is abandoned; together with the
    // entry cycle this gives exactly 255 cycles of mem_req.
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;

    logic [1:0] r_state;
    logic [2:0] r_pend;
    logic [2:0] r_we;
    logic [2:0] r_grant;
    logic       r_cur_we;
    logic [7:0] r_count;
    logic       r_overrun;
    logic       r_timeout;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic       r_rr_op_next;
`endif

    logic [2:0] w_set;
    logic [2:0] w_wr;
    logic       w_dual;
    logic       w_overrun_set;
    logic       w_grant_now;
    logic [2:0] w_winner;
    logic [2:0] w_clr;
    logic       w_timeout_hit;
    logic       w_in_busy;
    logic       w_in_reply;

    // Collect the request pulses per slot (bit0 op, bit1 io, bit2 pnl) and
    // the write flag each one would load. A simultaneous read+write on the
    // same requester is recorded as a write because w_wr wins.
    assign w_set = {bus.pnl_read_from_pnl | bus.pnl_write_from_pnl,
                    bus.io_write_from_io,
                    bus.op_read_from_op   | bus.op_write_from_op};
    assign w_wr  = {bus.pnl_write_from_pnl,
                    bus.io_write_from_io,
                    bus.op_write_from_op};

    // Overrun is raised either by a conflicting read+write pair or by a new
    // pulse for a slot that is still occupied at the moment it arrives.
    assign w_dual        = (bus.op_read_from_op  & bus.op_write_from_op) |
                           (bus.pnl_read_from_pnl & bus.pnl_write_from_pnl);
    assign w_overrun_set = w_dual | (|(w_set & r_pend));

    assign w_in_busy     = (r_state == ST_BUSY);
    assign w_in_reply    = (r_state == ST_REPLY);
    assign w_grant_now   = (r_state == ST_IDLE) && (|r_pend);
    assign w_timeout_hit = w_in_busy && !bus.mem_ack_from_mem &&
                           (r_count == TIMEOUT_LAST);

    // Winner selection. The panel always wins; the only open choice is an
    // op/io tie, which is fixed io-first unless round robin is built in, in
    // which case it follows the alternation flag.
    always_comb begin
        w_winner = 3'b000;
        if (r_pend[2]) begin
            w_winner = 3'b100;
        end else if (r_pend[1] && r_pend[0]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w_winner = r_rr_op_next ? 3'b001 : 3'b010;
`else
            w_winner = 3'b010;
`endif
        end else if (r_pend[1]) begin
            w_winner = 3'b010;
        end else if (r_pend[0]) begin
            w_winner = 3'b001;
        end
    end

    assign w_clr = w_grant_now ? w_winner : 3'b000;

    // Pending and write flags per slot. A new pulse always sets the slot,
    // even on the very edge where the grant is clearing it, so the request
    // arriving at grant time is not lost. The write flag is simply replaced
    // by the newest pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 3'b000;
            r_we   <= 3'b000;
        end else begin
            r_pend <= w_set | (r_pend & ~w_clr);
            r_we   <= (w_set & w_wr) | (~w_set & r_we);
        end
    end

    // Main access state machine. The grant and the winner's write flag are
    // captured on entry to BUSY so later pulses from the same requester
    // cannot disturb the access in flight. The grant is held through REPLY
    // so the reply pulse can be steered from it, then dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= 3'b000;
            r_cur_we <= 1'b0;
            r_count  <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_now) begin
                        r_grant  <= w_winner;
                        r_cur_we <= |(w_winner & r_we);
                        r_count  <= 8'd0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ack_from_mem) begin
                        r_state <= ST_REPLY;
                    end else if (w_timeout_hit) begin
                        r_grant  <= 3'b000;
                        r_cur_we <= 1'b0;
                        r_count  <= 8'd0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                ST_REPLY: begin
                    r_grant  <= 3'b000;
                    r_cur_we <= 1'b0;
                    r_count  <= 8'd0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_grant  <= 3'b000;
                    r_cur_we <= 1'b0;
                    r_count  <= 8'd0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round-robin memory: remembers which of op/io should win the next tie.
    // Only op and io grants move it; panel grants leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_op_next <= 1'b0;
        end else if (w_grant_now) begin
            if (w_winner[0]) begin
                r_rr_op_next <= 1'b0;
            end else if (w_winner[1]) begin
                r_rr_op_next <= 1'b1;
            end
        end
    end
`endif

    // Sticky error flags. A set arriving in the same cycle as the panel's
    // clear must survive, so set is checked before clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_error_from_pnl) begin
                r_overrun <= 1'b0;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end else if (bus.clear_error_from_pnl) begin
                r_timeout <= 1'b0;
            end
        end
    end

    // Outputs are decoded from registered state only, so they all read zero
    // in the cycle after a reset edge.
    assign bus.mem_req_to_mem        = w_in_busy;
    assign bus.mem_we_to_mem         = w_in_busy & r_cur_we;
    assign bus.grant_to_mem          = r_grant;
    assign bus.mem_reply_to_op       = w_in_reply & r_grant[0];
    assign bus.mem_write_reply_to_io = w_in_reply & r_grant[1];
    assign bus.mem_reply_to_pnl      = w_in_reply & r_grant[2];
    assign bus.busy_to_pnl           = (r_state != ST_IDLE) | (|r_pend);
    assign bus.overrun_to_pnl        = r_overrun;
    assign bus.timeout_to_pnl        = r_timeout;

endmodule
